pmc_dconf_shifter: RTL and testbench

- Consumer (slave end) of the pmc_digital_conf interface.
- On a start request, snapshots the 32-bit digital configuration word {res, th} and serialises it MSB-first into the pixel-matrix digital-configuration shift chain.
- Drives the chain's serial clock, data and latch strobe, then pulses done.
- Sits between the PMC register block (interface master) and the pixel-matrix config pins.

---
 rtl/pmc_dconf_shifter_if.sv | 9 +
 rtl/pmc_dconf_shifter.sv | 153 +++++++++++++++
 tb/tb_pmc_dconf_shifter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pmc_dconf_shifter_if.sv
// pmc_digital_conf: 32-bit pixel-matrix digital configuration word.
// res = upper 24 bits, th = lower 8 bits; master = register block.
interface pmc_digital_conf;
    logic [23:0] res;
    logic [7:0]  th;

    modport master (output res, th);
    modport slave  (input  res, th);
endinterface

// File: rtl/pmc_dconf_shifter.sv
// pmc_dconf_shifter: serialises {res, th} MSB-first into the pixel-matrix
// digital-configuration chain, then strobes the chain latch and pulses done.
// Ports:
//   clk, rst_n    system clock, async active-low reset
//   digital_conf  pmc_digital_conf.slave word source (sampled on start)
//   start         single-cycle transfer request (ignored unless idle)
//   busy, done    transfer in progress / one-cycle completion pulse
//   sclk, sdata   chain serial clock (chain samples on rise) and data
//   strobe        chain parallel-load latch, active high
// Optional build macro PMC_DCONF_READBACK_EN adds sdata_in, rb_data and
// rb_mismatch: the chain tail is captured on every sclk rise and compared
// with the transferred word at latch time.
module pmc_dconf_shifter #(
    parameter int CLK_DIV = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    pmc_digital_conf.slave digital_conf,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           sclk,
    output logic           sdata,
    output logic           strobe
`ifdef PMC_DCONF_READBACK_EN
    ,
    input  logic           sdata_in,
    output logic [31:0]    rb_data,
    output logic           rb_mismatch
`endif
);

    localparam int CONF_W = 32;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0] BIT_LAST = 5'(CONF_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;

    state_t            state, state_n;
    logic [CONF_W-1:0] shreg, shreg_n;
    logic [4:0]        bit_cnt, bit_n;
    logic [7:0]        div_cnt, div_n;
    logic              busy_n, done_n, sclk_n, strobe_n;
    logic              half_end;

    // The shift register drains to zero after 32 shifts, so its MSB is
    // also the registered data line outside SHIFT.
    assign sdata    = shreg[CONF_W-1];
    assign half_end = (div_cnt == DIV_LAST);

    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        bit_n    = bit_cnt;
        div_n    = div_cnt;
        busy_n   = busy;
        done_n   = 1'b0;
        sclk_n   = sclk;
        strobe_n = strobe;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = SHIFT;
                    shreg_n = {digital_conf.res, digital_conf.th};
                    bit_n   = 5'd0;
                    div_n   = 8'd0;
                    busy_n  = 1'b1;
                    sclk_n  = 1'b0;
                end
            end
            SHIFT: begin
                div_n = div_cnt + 8'd1;
                if (half_end) begin
                    div_n = 8'd0;
                    if (!sclk) begin
                        sclk_n = 1'b1;
                    end else begin
                        sclk_n  = 1'b0;
                        shreg_n = {shreg[CONF_W-2:0], 1'b0};
                        bit_n   = bit_cnt + 5'd1;
                        if (bit_cnt == BIT_LAST) begin
                            state_n  = LATCH;
                            strobe_n = 1'b1;
                        end
                    end
                end
            end
            LATCH: begin
                div_n = div_cnt + 8'd1;
                if (half_end) begin
                    div_n    = 8'd0;
                    strobe_n = 1'b0;
                    busy_n   = 1'b0;
                    done_n   = 1'b1;
                    state_n  = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= 5'd0;
            div_cnt <= 8'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sclk    <= 1'b0;
            strobe  <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bit_cnt <= bit_n;
            div_cnt <= div_n;
            busy    <= busy_n;
            done    <= done_n;
            sclk    <= sclk_n;
            strobe  <= strobe_n;
        end
    end

`ifdef PMC_DCONF_READBACK_EN
    logic [CONF_W-1:0] word_q;
    logic              sclk_rise;

    // Capture happens on the same edge that raises sclk, i.e. before the
    // chain itself shifts, so rb_data sees the bit leaving the chain tail.
    assign sclk_rise = (state == SHIFT) && half_end && !sclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q      <= '0;
            rb_data     <= '0;
            rb_mismatch <= 1'b0;
        end else begin
            if (state == IDLE && start)
                word_q <= {digital_conf.res, digital_conf.th};
            if (sclk_rise)
                rb_data <= {rb_data[CONF_W-2:0], sdata_in};
            if (state == LATCH && half_end)
                rb_mismatch <= (rb_data != word_q);
        end
    end
`endif

endmodule

// File: tb/tb_pmc_dconf_shifter.sv
// Bench for pmc_dconf_shifter: two instances (CLK_DIV=2 and 1) checked
// every cycle against a transfer-timeline model plus literal checks.
module tb_pmc_dconf_shifter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0;
    int n_fail = 0;

    pmc_digital_conf dc2 ();
    pmc_digital_conf dc1 ();

    logic st2 = 1'b0;
    logic st1 = 1'b0;
    logic busy2, done2, sclk2, sdata2, strobe2;
    logic busy1, done1, sclk1, sdata1, strobe1;

`ifdef PMC_DCONF_READBACK_EN
    logic [31:0] chain2;
    logic [31:0] rb2, rb1;
    logic        mm2, mm1;
    always @(posedge sclk2 or negedge rst_n)
        if (!rst_n) chain2 <= '0;
        else        chain2 <= {chain2[30:0], sdata2};
`endif

    pmc_dconf_shifter #(.CLK_DIV(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .digital_conf(dc2), .start(st2),
        .busy(busy2), .done(done2), .sclk(sclk2), .sdata(sdata2),
        .strobe(strobe2)
`ifdef PMC_DCONF_READBACK_EN
        , .sdata_in(chain2[31]), .rb_data(rb2), .rb_mismatch(mm2)
`endif
    );

    pmc_dconf_shifter #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .digital_conf(dc1), .start(st1),
        .busy(busy1), .done(done1), .sclk(sclk1), .sdata(sdata1),
        .strobe(strobe1)
`ifdef PMC_DCONF_READBACK_EN
        , .sdata_in(1'b0), .rb_data(rb1), .rb_mismatch(mm1)
`endif
    );

    // outputs packed as {busy, done, sclk, sdata, strobe}
    function automatic logic [4:0] outs(int i);
        if (i == 0) return {busy2, done2, sclk2, sdata2, strobe2};
        return {busy1, done1, sclk1, sdata1, strobe1};
    endfunction

    // ---- model: a transfer is a timeline of 65*D+1 cycles from start ----
    int          dv [2] = '{2, 1};
    bit          act[2];
    int          kk [2];
    logic [31:0] ww [2];

    task automatic step(input int i, input logic s, input logic [31:0] w);
        if (act[i]) begin
            kk[i]++;
            if (kk[i] > 65 * dv[i]) act[i] = 1'b0;
        end else if (s) begin
            act[i] = 1'b1;
            kk[i]  = 0;
            ww[i]  = w;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act[0] = 1'b0;
            act[1] = 1'b0;
        end else begin
            step(0, st2, {dc2.res, dc2.th});
            step(1, st1, {dc1.res, dc1.th});
        end
    end

    function automatic logic [4:0] expv(int i);
        int d;
        int k;
        d = dv[i];
        k = kk[i];
        if (!act[i]) return 5'b00000;
        if (k < 64 * d)
            return {1'b1, 1'b0, (k % (2 * d)) >= d,
                    ww[i][31 - k / (2 * d)], 1'b0};
        if (k < 65 * d) return 5'b10001;
        return 5'b01000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, got, exp,
                     $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cycle_d2", 32'(outs(0)), 32'(expv(0)));
        chk("cycle_d1", 32'(outs(1)), 32'(expv(1)));
    end

    // ---- stimulus helpers ----
    task automatic set_conf(input int i, input logic [31:0] w);
        if (i == 0) begin dc2.res = w[31:8]; dc2.th = w[7:0]; end
        else        begin dc1.res = w[31:8]; dc1.th = w[7:0]; end
    endtask

    task automatic set_st(input int i, input logic v);
        if (i == 0) st2 = v;
        else        st1 = v;
    endtask

    int          lat, rises, strb, dones, busyc, sdh;
    logic [31:0] cap;

    // One transfer on instance i. re: negedge index after the start edge
    // at which start is pulsed again (-1 = never); rd: re-pulse while done
    // is high; chg: clear th one cycle after the start sample.
    task automatic xfer(input int i, input logic [31:0] w, input int re,
                        input bit rd, input bit chg);
        int   n;
        logic prev;
        logic [4:0] o;
        @(negedge clk);
        set_conf(i, w);
        set_st(i, 1'b1);
        @(negedge clk);
        n = cyc;
        set_st(i, 1'b0);
        lat = -1; rises = 0; strb = 0; dones = 0; busyc = 0; sdh = 0;
        cap = '0;
        prev = 1'b0;
        if (chg) begin
            if (i == 0) dc2.th = 8'h00;
            else        dc1.th = 8'h00;
        end
        for (int t = 0; t < 65 * dv[i] + 8; t++) begin
            o = outs(i);
            if (o[4]) busyc++;
            if (o[0]) strb++;
            if (o[1]) sdh++;
            if (o[3]) begin
                dones++;
                if (lat < 0) lat = cyc - n;
            end
            if (o[2] && !prev) begin
                rises++;
                cap = {cap[30:0], o[1]};
            end
            prev = o[2];
            set_st(i, (t == re) || (rd && o[3]));
            @(negedge clk);
        end
        set_st(i, 1'b0);
        if (lat < 0) chk("done_timeout", 32'(lat), 32'(65 * dv[i]));
    endtask

    logic [31:0] w;

    initial begin
        dc2.res = '0; dc2.th = '0;
        dc1.res = '0; dc1.th = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", 32'({outs(0), outs(1)}), 32'd0);
        rst_n = 1'b1;

`ifdef PMC_DCONF_READBACK_EN
        xfer(0, 32'h12345678, -1, 1'b0, 1'b0);
        chk("rb_first_data", rb2, 32'h0);
        chk("rb_first_mm", 32'(mm2), 32'd1);
        xfer(0, 32'h12345678, -1, 1'b0, 1'b0);
        chk("rb_second_data", rb2, 32'h12345678);
        chk("rb_second_mm", 32'(mm2), 32'd0);
`endif

        // CLK_DIV=2 main pattern
        xfer(0, 32'hA5A5A53C, -1, 1'b0, 1'b0);
        chk("d2_latency", 32'(lat), 32'd130);
        chk("d2_rises", 32'(rises), 32'd32);
        chk("d2_word", cap, 32'hA5A5A53C);
        chk("d2_strobe_len", 32'(strb), 32'd2);
        chk("d2_busy_len", 32'(busyc), 32'd130);
        chk("d2_done_cnt", 32'(dones), 32'd1);

        // snapshot of th at the start edge
        xfer(0, 32'h5A0013FF, -1, 1'b0, 1'b1);
        chk("snap_word", cap, 32'h5A0013FF);

        // re-pulses while busy and during done are ignored
        xfer(0, 32'hC0FFEE11, 5, 1'b1, 1'b0);
        chk("repulse_done_cnt", 32'(dones), 32'd1);
        chk("repulse_busy_len", 32'(busyc), 32'd130);
        chk("repulse_latency", 32'(lat), 32'd130);
        chk("repulse_word", cap, 32'hC0FFEE11);

        // CLK_DIV=1 boundary
        xfer(1, 32'h00000001, -1, 1'b0, 1'b0);
        chk("d1_latency", 32'(lat), 32'd65);
        chk("d1_rises", 32'(rises), 32'd32);
        chk("d1_word", cap, 32'h00000001);
        chk("d1_sdata_high", 32'(sdh), 32'd2);
        chk("d1_strobe_len", 32'(strb), 32'd1);

        // randomized transfers
        for (int r = 0; r < 10; r++) begin
            int i;
            int re;
            i  = int'($urandom_range(0, 1));
            w  = $urandom;
            re = int'($urandom_range(0, 200));
            xfer(i, w, re, 1'($urandom_range(0, 1)), 1'b0);
            chk("rnd_word", cap, w);
            chk("rnd_done_cnt", 32'(dones), 32'd1);
            chk("rnd_latency", 32'(lat), 32'(65 * dv[i]));
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        // asynchronous reset in the middle of SHIFT
        @(negedge clk);
        set_conf(0, 32'hFFFFFFFF);
        st2 = 1'b1;
        @(negedge clk);
        st2 = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 32'({outs(0), outs(1)}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        strb = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (strobe2) strb++;
        end
        chk("no_strobe_after_rst", 32'(strb), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
